// File: rtl/uart_rx_fc.sv
// uart_rx_fc: UART receiver with 2-FF synchroniser, 3-sample majority vote and configurable framing.
// Completed words sit in a valid/ready output register with parity, framing and overrun flags.
module uart_rx_fc #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int L  = DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_DATA = IW'(DATA_BITS);
  localparam logic [IW-1:0] I_LAST = IW'(L);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [1:0]           sync_q;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                 par_q, par_d, ferr_q, ferr_d;
  logic                 valid_q, valid_d, perr_q, perr_d, fe_q, fe_d, ovr_q, ovr_d;
  logic                 rx_s, decide, bit_end, vote, done, load, xsum, perr_now;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sync_q  <= 2'b11;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sync_q  <= {sync_q[0], rx_i};
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = bit_end ? idx_q + IW'(1) : idx_q;
    case (state_q)
      S_IDLE: begin
        state_d = rx_s ? S_IDLE : S_START;
        cnt_d   = CW'(1);
      end
      S_START: state_d = (decide && vote) ? S_IDLE : bit_end ? S_DATA : S_START;
      S_DATA:  state_d = (bit_end && idx_q == I_DATA) ? ((PARITY != 0) ? S_PAR : S_STOP) : S_DATA;
      S_PAR:   state_d = bit_end ? S_STOP : S_PAR;
      S_STOP:  state_d = done ? S_IDLE : S_STOP;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_comb begin
    rx_s    = sync_q[1];
    decide  = cnt_q == C_DEC;
    bit_end = cnt_q == C_LAST;
    vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    done    = state_q == S_STOP && decide && idx_q == I_LAST;
    busy_o  = state_q != S_IDLE;
  end

  // The final stop-bit vote is folded in combinationally so the word loads on the decision edge.
  always_comb begin
    s0_d     = (state_q != S_IDLE && cnt_q == C_S0) ? rx_s : s0_q;
    s1_d     = (state_q != S_IDLE && cnt_q == C_S1) ? rx_s : s1_q;
    shreg_d  = (state_q == S_DATA && decide) ? {vote, shreg_q[DATA_BITS-1:1]} : shreg_q;
    par_d    = (state_q == S_PAR && decide) ? vote : par_q;
    ferr_d   = (state_q == S_IDLE) ? 1'b0 : (state_q == S_STOP && decide && !vote) ? 1'b1 : ferr_q;
    xsum     = ^shreg_q ^ par_q;
    perr_now = (PARITY == 1) ? ~xsum : (PARITY == 2) ? xsum : 1'b0;
    load     = done && (!valid_q || ready_i);
    data_d   = load ? shreg_q : data_q;
    perr_d   = load ? perr_now : perr_q;
    fe_d     = load ? (ferr_q | ~vote) : fe_q;
    valid_d  = load ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
    ovr_d    = load ? 1'b0 : done ? 1'b1 : (valid_q && ready_i) ? 1'b0 : ovr_q;
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = fe_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx_fc.sv
// tb_uart_rx_fc: scoreboard bench for uart_rx_fc with 8N1, 7E1 and 8N2 instances at 16 clocks/bit.
`timescale 1ps/1ps
module tb_uart_rx_fc;
  localparam int N      = 16;
  localparam int CLK_PS = 10000;
  localparam int BIT_PS = N * CLK_PS;

  typedef struct packed { logic [8:0] d; logic pe; logic fe; } exp_t;

  logic clk = 1'b0, resetn = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, bz0, bz1, bz2;
  int cyc = 0, checks = 0, failures = 0;
  exp_t q0[$], q1[$], q2[$];

  always #(CLK_PS/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fc #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .resetn(resetn), .rx_i(rx0), .data_o(d0), .valid_o(v0), .ready_i(rdy0),
    .parity_err_o(pe0), .frame_err_o(fe0), .overrun_o(ov0), .busy_o(bz0));
  uart_rx_fc #(.CLKS_PER_BIT(N), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .resetn(resetn), .rx_i(rx1), .data_o(d1), .valid_o(v1), .ready_i(rdy1),
    .parity_err_o(pe1), .frame_err_o(fe1), .overrun_o(ov1), .busy_o(bz1));
  uart_rx_fc #(.CLKS_PER_BIT(N), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .resetn(resetn), .rx_i(rx2), .data_o(d2), .valid_o(v2), .ready_i(rdy2),
    .parity_err_o(pe2), .frame_err_o(fe2), .overrun_o(ov2), .busy_o(bz2));

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic mon(input int k, input logic [8:0] d, input logic pe, input logic fe);
    exp_t x;
    int n;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_word dut%0d got=%0h expected=none", k, d);
      return;
    end
    case (k)
      0: x = q0.pop_front();
      1: x = q1.pop_front();
      default: x = q2.pop_front();
    endcase
    check($sformatf("dut%0d_data", k), d, x.d);
    check($sformatf("dut%0d_parity_err", k), pe, x.pe);
    check($sformatf("dut%0d_frame_err", k), fe, x.fe);
  endtask

  always @(negedge clk) if (resetn) begin
    if (v0 && rdy0) mon(0, {1'b0, d0}, pe0, fe0);
    if (v1 && rdy1) mon(1, {2'b0, d1}, pe1, fe1);
    if (v2 && rdy2) mon(2, {1'b0, d2}, pe2, fe2);
  end

  task automatic drive(input int k, input logic v);
    if (k == 0) rx0 = v;
    else if (k == 1) rx1 = v;
    else rx2 = v;
  endtask

  // Reference: a frame delivers its data; parity/framing flags follow from the bits put on the line.
  task automatic push(input int k, input int nd, input int pm, input int ns, input logic [8:0] d,
                      input bit pflip, input logic [1:0] stops);
    exp_t x;
    logic par, pb;
    x.d  = d & 9'((1 << nd) - 1);
    par  = ^x.d;
    pb   = ((pm == 1) ? ~par : par) ^ pflip;
    x.pe = (pm == 1) ? ~(par ^ pb) : (pm == 2) ? (par ^ pb) : 1'b0;
    x.fe = (ns == 2) ? ~(stops[0] & stops[1]) : ~stops[0];
    case (k)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic frame(input int k, input int nd, input int pm, input int ns, input logic [8:0] d,
                       input bit pflip, input logic [1:0] stops, input int bit_ps, input int gl,
                       input bit want);
    logic bits[$];
    logic p;
    if (want) push(k, nd, pm, ns, d, pflip, stops);
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (pm != 0) bits.push_back(((pm == 1) ? ~p : p) ^ pflip);
    for (int i = 0; i < ns; i++) bits.push_back(stops[i]);
    foreach (bits[i]) begin
      drive(k, bits[i]);
      if (i == gl) begin
        #(N / 2 * CLK_PS) drive(k, ~bits[i]);
        #(CLK_PS) drive(k, bits[i]);
        #(bit_ps - (N / 2 + 1) * CLK_PS);
      end else #(bit_ps);
    end
    drive(k, 1'b1);
  endtask

  task automatic align();
    @(posedge clk);
    #1000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) align();
  endtask

  task automatic wait_valid0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (v0) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at, e;
    #(2 * CLK_PS + 1000);
    check("rst_data", d0, 0);
    check("rst_valid", v0, 0);
    check("rst_parity_err", pe0, 0);
    check("rst_frame_err", fe0, 0);
    check("rst_overrun", ov0, 0);
    check("rst_busy", bz0, 0);
    check("rst_valid_7e1", v1, 0);
    check("rst_valid_8n2", v2, 0);
    align();
    resetn = 1'b1;
    idle(4);

    align();
    e = cyc + 1;
    fork
      frame(0, 8, 0, 1, 9'h0A5, 1'b0, 2'b11, BIT_PS, -1, 1'b1);
      begin
        wait_valid0(200, at);
        check("latency", at, e + 155);
        check("busy_fall", bz0, 0);
        @(negedge clk);
        check("valid_one_cycle", v0, 0);
      end
      begin
        do @(negedge clk); while (cyc < e + 1);
        check("busy_before_e2", bz0, 0);
        @(negedge clk);
        check("busy_after_e2", bz0, 1);
      end
    join
    idle(2 * N);

    align();
    frame(1, 7, 2, 1, 9'h055, 1'b0, 2'b11, BIT_PS, -1, 1'b1);
    idle(2 * N);
    align();
    frame(1, 7, 2, 1, 9'h055, 1'b1, 2'b11, BIT_PS, -1, 1'b1);
    idle(2 * N);
    for (int i = 0; i < 8; i++) begin
      align();
      frame(1, 7, 2, 1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11, BIT_PS, -1, 1'b1);
      idle(2 * N);
    end

    align();
    frame(2, 8, 0, 2, 9'h0C3, 1'b0, 2'b01, BIT_PS, -1, 1'b1);
    idle(2 * N);
    for (int i = 0; i < 6; i++) begin
      align();
      frame(2, 8, 0, 2, 9'($urandom_range(0, 255)), 1'b0, 2'($urandom_range(0, 3)), BIT_PS, -1, 1'b1);
      idle(2 * N);
    end

    align();
    e = cyc + 1;
    rx0 = 1'b0;
    #(4 * CLK_PS) rx0 = 1'b1;
    do @(negedge clk); while (cyc < e + 3);
    check("glitch_start_busy", bz0, 1);
    do @(negedge clk); while (cyc < e + 16);
    check("glitch_busy_clear", bz0, 0);
    check("glitch_no_valid", v0, 0);
    idle(N);

    for (int i = 1; i <= 8; i++) begin
      align();
      frame(0, 8, 0, 1, 9'($urandom_range(0, 255)), 1'b0, 2'b11, BIT_PS, i, 1'b1);
      idle(N);
    end

    rdy0 = 1'b0;
    align();
    frame(0, 8, 0, 1, 9'h011, 1'b0, 2'b11, BIT_PS, -1, 1'b1);
    idle(2 * N);
    align();
    frame(0, 8, 0, 1, 9'h022, 1'b0, 2'b11, BIT_PS, -1, 1'b0);
    idle(4);
    @(negedge clk);
    check("ovr_data_held", d0, 8'h11);
    check("ovr_flag", ov0, 1);
    check("ovr_valid", v0, 1);
    align();
    rdy0 = 1'b1;
    align();
    rdy0 = 1'b0;
    @(negedge clk);
    check("xfer_valid_clr", v0, 0);
    check("xfer_ovr_clr", ov0, 0);

    align();
    frame(0, 8, 0, 1, 9'h011, 1'b0, 2'b11, BIT_PS, -1, 1'b1);
    idle(2 * N);
    align();
    e = cyc + 1;
    fork
      frame(0, 8, 0, 1, 9'h022, 1'b0, 2'b11, BIT_PS, -1, 1'b1);
      begin
        wait_edge(e + 154);
        rdy0 = 1'b1;
        align();
        rdy0 = 1'b0;
      end
    join
    @(negedge clk);
    check("swap_data", d0, 8'h22);
    check("swap_no_ovr", ov0, 0);
    check("swap_valid", v0, 1);
    align();
    rdy0 = 1'b1;
    idle(2);

    align();
    rx0 = 1'b0;
    #(4 * BIT_PS + BIT_PS / 2);
    resetn = 1'b0;
    #1000;
    check("midrst_busy", bz0, 0);
    check("midrst_data", d0, 0);
    check("midrst_valid", v0, 0);
    check("midrst_frame_err", fe0, 0);
    rx0 = 1'b1;
    align();
    resetn = 1'b1;
    idle(2 * N);
    align();
    frame(0, 8, 0, 1, 9'h03C, 1'b0, 2'b11, BIT_PS, -1, 1'b1);
    idle(2 * N);

    align();
    for (int i = 0; i < 64; i++)
      frame(0, 8, 0, 1, 9'($urandom_range(0, 255)), 1'b0, 2'b11, BIT_PS + BIT_PS * 15 / 1000, -1, 1'b1);
    idle(3 * N);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fc.md
# uart_rx_fc

Parametrised UART receiver: the next generation of the 8N1 receiver in the serial front end. Adds configurable data width, parity and stop-bit count, a 2-FF input synchroniser and 3-sample majority voting per bit. Received words are held in an output register under a valid/ready handshake, with per-word parity/framing error flags and overrun reporting. It sits between the pad-side `rx_i` line and the byte consumer (command parser or FIFO).

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit. Legal range is ≥ 8. `H = CLKS_PER_BIT/2` (floor).
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk` in 1: clock. One clock domain.
- `resetn` in 1: reset. Asynchronous, active-low.
- `rx_i` in 1: serial line. Asynchronous to `clk`; idles high.
- `data_o` out DATA_BITS: received word, held while `valid_o` is high.
- `valid_o` out 1: word available.
- `ready_i` in 1: consumer accepts. A transfer occurs when `valid_o & ready_i`.
- `parity_err_o` out 1: parity mismatch for the held word. Always 0 when `PARITY=0`.
- `frame_err_o` out 1: at least one stop bit of the held word was voted 0.
- `overrun_o` out 1: at least one complete frame was discarded since the last transfer.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Input synchroniser:
  - `rx_i` passes through 2 flops to produce `rx_s`.
  - Both flops reset to 1, so no false start is generated out of reset.
- Counters:
  - `cnt` counts 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at a bit boundary.
  - `bit_idx` counts the bits of the frame (start = 0).
- Sampling:
  - `rx_s` is captured at `cnt` = H-1, H and H+1.
  - The bit value is the majority of the 3 samples, decided at `cnt` = H+1.
- States:
  - IDLE: `cnt`=0. If `rx_s`=0 → START with `cnt`<=1.
  - START: at the decision point, vote 1 → IDLE (glitch rejected, nothing reported). Vote 0 → continue; at the bit end → DATA.
  - DATA: shift the voted value into `shreg[bit_idx-1]`. After DATA_BITS bits → PARITY if `PARITY`≠0, else STOP.
  - PARITY: record the voted parity bit. Odd mode requires XOR(data, parity) = 1; even mode requires 0. Then → STOP.
  - STOP: each stop bit is voted; any 0 sets the frame error. With `STOP_BITS`=2, the first stop bit runs its full length.
  - At the decision point of the last stop bit: complete the frame → IDLE immediately. The remaining half bit is not waited for, so back-to-back frames resynchronise on the next start edge.
- Completion:
  - `valid_o`=0, or `ready_i`=1 in the same cycle: load `data_o`, `parity_err_o`, `frame_err_o`; set `valid_o`. A simultaneous completion and transfer loses nothing.
  - `valid_o`=1 and `ready_i`=0: discard the new frame, keep the held word, set `overrun_o`.
- A transfer with no completion in the same cycle clears `valid_o` and `overrun_o`.
- A frame with a framing or parity error is still delivered, flagged.
- `resetn` low at any time, including mid-frame: all state returns to IDLE immediately (asynchronous) and any partial frame is discarded.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `parity_err_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
- Latency: let L = DATA_BITS + (PARITY≠0) + STOP_BITS, and let edge e be the first edge at which `rx_i` is sampled 0. `valid_o` rises after edge e + L·CLKS_PER_BIT + H + 3.
- `busy_o` rises after edge e+2 and falls together with the `valid_o` rise.
- Error flags change only on the cycle a word is loaded.
- `data_o` is stable while `valid_o`=1 and `ready_i`=0.
- `ready_i` may be held high permanently; the receiver never stalls the line.
- A start glitch shorter than 2 of the 3 samples does not start a frame.

## Test plan
- Basic receive: CLKS_PER_BIT=16, 8N1, send 0xA5 with `ready_i`=1 → `valid_o` high exactly 155 cycles after edge e, `data_o`=0xA5, both error flags 0, `valid_o` high for 1 cycle.
- Parity: 7 data bits, even parity, send 0x55 with the parity bit correct → `parity_err_o`=0. Resend with the parity bit inverted → `data_o`=0x55, `parity_err_o`=1.
- Framing error and noise rejection:
  - 8N2, second stop bit driven 0 → `frame_err_o`=1, data delivered.
  - 8N1 stimulus: `rx_i` low for 4 cycles then high → no frame, `busy_o` back to 0 within 16 cycles.
  - 8N1 stimulus: a 1-cycle glitch on one data bit at `cnt`=H → bit value unaffected.
- Overrun and handshake:
  - `ready_i`=0, send 0x11 then 0x22 → `data_o` stays 0x11, `overrun_o`=1.
  - Assert `ready_i` for 1 cycle → `valid_o`=0, `overrun_o`=0.
  - Repeat with `ready_i` pulsed in the completion cycle of 0x22 → `data_o`=0x22, no overrun.
- Reset mid-frame and back-to-back:
  - Assert `resetn`=0 during data bit 3 → all outputs 0 immediately. Next frame 0x3C is received correctly.
  - Send 64 back-to-back 8N1 frames at 1.5% baud mismatch → all 64 correct, no errors.
